// File: rtl/mem_io_unit.sv
// Memory-stage responder: main RAM, call stack, program-memory write strobe and
// arbitrated frame-buffer port. Define FB_WBUF_EN to enable the posted-write FIFO.
module mem_io_unit #(
   parameter int MAIN_AW       = 12,
   parameter int CSTK_AW       = 8,
   parameter int FB_WBUF_DEPTH = 4
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic        main_mem_en,
   input  logic        fb_en,
   input  logic        call_stk_en,
   input  logic        prog_mem_en,
   input  logic        mem_wen,
   input  logic [16:0] mem_addr,
   input  logic [7:0]  call_stk_addr,
   input  logic [11:0] write_data,
   output logic [11:0] read_data,
   input  logic [13:0] call_stk_write_data,
   output logic [13:0] call_stk_read_data,
   output logic        mem_stall,
   output logic        mem_err,
   input  logic        fb_vid_req,
   output logic        fb_port_en,
   output logic        fb_port_wen,
   output logic [16:0] fb_port_addr,
   output logic [11:0] fb_port_wdata,
   input  logic [11:0] fb_port_rdata,
   output logic        prog_wr_en,
   output logic [13:0] prog_wr_addr,
   output logic [11:0] prog_wr_data
);

   typedef enum logic [1:0] {FB_IDLE, FB_DRAIN, FB_RD} fb_state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_MAIN, TAG_FB, TAG_ZERO} rd_tag_t;

   fb_state_t   r_state, w_next_state;
   rd_tag_t     r_rd_tag;
   logic [2:0]  w_req_cnt;
   logic        w_illegal, w_main_req, w_fb_req, w_cstk_req, w_prog_req;
   logic        w_stall, w_port_en, w_port_wen, w_fb_rd_issue;
   logic [16:0] w_port_addr;
   logic [11:0] w_port_wdata, w_read_data;

   logic [11:0] r_main_mem [0:(1<<MAIN_AW)-1];
   logic [13:0] r_cstk_mem [0:(1<<CSTK_AW)-1];
   logic [11:0] r_main_q, r_fb_q;
   logic [13:0] r_cstk_q;
   logic        r_err, r_prog_wr_en;
   logic [13:0] r_prog_wr_addr;
   logic [11:0] r_prog_wr_data;

   assign w_req_cnt  = {2'b00, main_mem_en} + {2'b00, fb_en} + {2'b00, call_stk_en} + {2'b00, prog_mem_en};
   assign w_illegal  = (w_req_cnt > 3'd1);
   assign w_main_req = main_mem_en & ~w_illegal;
   assign w_fb_req   = fb_en & ~w_illegal;
   assign w_cstk_req = call_stk_en & ~w_illegal;
   assign w_prog_req = prog_mem_en & ~w_illegal;

   // NOTE: storage arrays sit in clock-only processes; resetting RAM contents is neither needed nor mappable to block RAM.
   always_ff @(posedge clock) begin
      if (w_main_req && mem_wen) r_main_mem[mem_addr[MAIN_AW-1:0]] <= write_data;
      if (w_main_req && !mem_wen) r_main_q <= r_main_mem[mem_addr[MAIN_AW-1:0]];
      if (w_cstk_req && mem_wen) r_cstk_mem[call_stk_addr[CSTK_AW-1:0]] <= call_stk_write_data;
   end

`ifdef FB_WBUF_EN
   localparam int PW = $clog2(FB_WBUF_DEPTH);

   logic [PW:0] r_wptr, r_rptr;
   logic [16:0] r_fifo_addr [0:FB_WBUF_DEPTH-1];
   logic [11:0] r_fifo_data [0:FB_WBUF_DEPTH-1];
   logic        w_push, w_pop, w_fifo_full, w_fifo_last;

   assign w_fifo_full = ((r_wptr ^ r_rptr) == {1'b1, {PW{1'b0}}});
   assign w_fifo_last = ((r_wptr - r_rptr) == (PW+1)'(1));

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_addr[r_wptr[PW-1:0]] <= mem_addr;
         r_fifo_data[r_wptr[PW-1:0]] <= write_data;
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end
`endif

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state  = r_state;
      w_stall       = 1'b0;
      w_port_en     = 1'b0;
      w_port_wen    = 1'b0;
      w_port_addr   = '0;
      w_port_wdata  = '0;
      w_fb_rd_issue = 1'b0;
`ifdef FB_WBUF_EN
      w_push        = 1'b0;
      w_pop         = 1'b0;
`endif
      case (r_state)
         FB_DRAIN: begin
`ifdef FB_WBUF_EN
            if (!fb_vid_req) begin
               w_pop        = 1'b1;
               w_port_en    = 1'b1;
               w_port_wen   = 1'b1;
               w_port_addr  = r_fifo_addr[r_rptr[PW-1:0]];
               w_port_wdata = r_fifo_data[r_rptr[PW-1:0]];
            end
            // Reads wait for the buffer to empty so they observe all posted writes.
            if (w_fb_req && mem_wen) begin
               if (!w_fifo_full || w_pop) w_push = 1'b1;
               else                      w_stall = 1'b1;
            end else if (w_fb_req) begin
               w_stall = 1'b1;
            end
            if (w_pop && w_fifo_last && !w_push) w_next_state = FB_IDLE;
`else
            w_next_state = FB_IDLE;
`endif
         end
         default: begin
            w_next_state = FB_IDLE;
            if (w_fb_req) begin
               if (!fb_vid_req) begin
                  w_port_en    = 1'b1;
                  w_port_wen   = mem_wen;
                  w_port_addr  = mem_addr;
                  w_port_wdata = mem_wen ? write_data : 12'd0;
                  if (!mem_wen) begin
                     w_fb_rd_issue = 1'b1;
                     w_next_state  = FB_RD;
                  end
               end else if (mem_wen) begin
`ifdef FB_WBUF_EN
                  w_push       = 1'b1;
                  w_next_state = FB_DRAIN;
`else
                  w_stall      = 1'b1;
`endif
               end else begin
                  w_stall = 1'b1;
               end
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_state        <= FB_IDLE;
         r_rd_tag       <= TAG_NONE;
         r_fb_q         <= '0;
         r_cstk_q       <= '0;
         r_err          <= 1'b0;
         r_prog_wr_en   <= 1'b0;
         r_prog_wr_addr <= '0;
         r_prog_wr_data <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == FB_RD) r_fb_q <= fb_port_rdata;
         if (w_main_req && !mem_wen)      r_rd_tag <= TAG_MAIN;
         else if (w_fb_rd_issue)          r_rd_tag <= TAG_FB;
         else if (w_prog_req && !mem_wen) r_rd_tag <= TAG_ZERO;
         if (w_cstk_req && !mem_wen) r_cstk_q <= r_cstk_mem[call_stk_addr[CSTK_AW-1:0]];
         if (w_illegal) r_err <= 1'b1;
         r_prog_wr_en <= w_prog_req & mem_wen;
         if (w_prog_req && mem_wen) begin
            r_prog_wr_addr <= mem_addr[13:0];
            r_prog_wr_data <= write_data;
         end
      end
   end

   always_comb begin
      case (r_rd_tag)
         TAG_MAIN: w_read_data = r_main_q;
         TAG_FB:   w_read_data = r_fb_q;
         default:  w_read_data = 12'd0;
      endcase
   end

   assign read_data          = w_read_data;
   assign call_stk_read_data = r_cstk_q;
   assign mem_stall          = w_stall;
   assign mem_err            = r_err;
   assign fb_port_en         = w_port_en;
   assign fb_port_wen        = w_port_wen;
   assign fb_port_addr       = w_port_addr;
   assign fb_port_wdata      = w_port_wdata;
   assign prog_wr_en         = r_prog_wr_en;
   assign prog_wr_addr       = r_prog_wr_addr;
   assign prog_wr_data       = r_prog_wr_data;

endmodule

// File: tb/tb_mem_io_unit.sv
// Self-checking bench for mem_io_unit: directed steps plus randomized main/call-stack
// traffic against array models, and a behavioural frame-buffer memory on the port.
module tb_mem_io_unit;

   logic        clock = 1'b0;
   logic        nreset;
   logic        main_mem_en, fb_en, call_stk_en, prog_mem_en, mem_wen;
   logic [16:0] mem_addr;
   logic [7:0]  call_stk_addr;
   logic [11:0] write_data;
   logic [11:0] read_data;
   logic [13:0] call_stk_write_data;
   logic [13:0] call_stk_read_data;
   logic        mem_stall, mem_err, fb_vid_req;
   logic        fb_port_en, fb_port_wen;
   logic [16:0] fb_port_addr;
   logic [11:0] fb_port_wdata;
   logic [11:0] fb_port_rdata = '0;
   logic        prog_wr_en;
   logic [13:0] prog_wr_addr;
   logic [11:0] prog_wr_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [11:0] fbmem [0:1023];
   logic [28:0] wr_log [$];
   int          wr_cyc [$];

   logic [11:0] m_main [0:4095];
   logic [13:0] m_cstk [0:255];
   logic [11:0] exp_rd;
   logic [13:0] exp_cs;

   mem_io_unit dut (
      .clock(clock), .nreset(nreset),
      .main_mem_en(main_mem_en), .fb_en(fb_en), .call_stk_en(call_stk_en), .prog_mem_en(prog_mem_en),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .call_stk_addr(call_stk_addr), .write_data(write_data),
      .read_data(read_data), .call_stk_write_data(call_stk_write_data), .call_stk_read_data(call_stk_read_data),
      .mem_stall(mem_stall), .mem_err(mem_err), .fb_vid_req(fb_vid_req),
      .fb_port_en(fb_port_en), .fb_port_wen(fb_port_wen), .fb_port_addr(fb_port_addr),
      .fb_port_wdata(fb_port_wdata), .fb_port_rdata(fb_port_rdata),
      .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr), .prog_wr_data(prog_wr_data)
   );

   always #5 clock = ~clock;

   // Frame-buffer memory: one-cycle read latency, logs every CPU-side port write.
   always @(posedge clock) begin
      cyc++;
      if (fb_port_en && !fb_vid_req) begin
         if (fb_port_wen) begin
            fbmem[fb_port_addr[9:0]] <= fb_port_wdata;
            wr_log.push_back({fb_port_addr, fb_port_wdata});
            wr_cyc.push_back(cyc);
         end else begin
            fb_port_rdata <= fbmem[fb_port_addr[9:0]];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      main_mem_en = 1'b0; fb_en = 1'b0; call_stk_en = 1'b0; prog_mem_en = 1'b0; mem_wen = 1'b0;
   endtask

   task automatic req(input int kind, input logic wen, input logic [16:0] a, input logic [11:0] d);
      idle();
      mem_wen = wen; mem_addr = a; write_data = d;
      case (kind)
         0: main_mem_en = 1'b1;
         1: fb_en = 1'b1;
         2: prog_mem_en = 1'b1;
         default: ;
      endcase
   endtask

   task automatic cs_req(input logic wen, input logic [7:0] a, input logic [13:0] d);
      idle();
      call_stk_en = 1'b1; mem_wen = wen; call_stk_addr = a; call_stk_write_data = d;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_read_data"}, 32'(read_data), 0);
      check({pfx, "_cstk_rd"}, 32'(call_stk_read_data), 0);
      check({pfx, "_stall"}, 32'(mem_stall), 0);
      check({pfx, "_err"}, 32'(mem_err), 0);
      check({pfx, "_port"}, {fb_port_en, fb_port_wen, fb_port_addr, fb_port_wdata}, 0);
      check({pfx, "_prog"}, {prog_wr_en, prog_wr_addr, prog_wr_data}, 0);
   endtask

   initial begin
      int k;
      logic [11:0] d;
      logic [3:0]  a;
      logic [4:0]  hi;
      nreset = 1'b0; fb_vid_req = 1'b0; idle();
      mem_addr = '0; call_stk_addr = '0; write_data = '0; call_stk_write_data = '0;
      #12;
      check_reset_outputs("reset");
      nreset = 1'b1;
      tick();

      // Main memory write/read and aliasing of upper address bits.
      req(0, 1'b1, 17'h00005, 12'hABC); m_main[5] = 12'hABC;
      #1 check("main_wr_stall", 32'(mem_stall), 0);
      tick();
      req(0, 1'b0, 17'h00005, 12'h000);
      tick(); idle();
      check("main_rd", 32'(read_data), 32'h0ABC);
      req(0, 1'b0, 17'h01005, 12'h000);
      tick(); idle();
      check("main_alias", 32'(read_data), 32'h0ABC);
      tick();
      check("main_hold", 32'(read_data), 32'h0ABC);
      exp_rd = 12'hABC;

      // Call stack write/read.
      cs_req(1'b1, 8'h10, 14'h2A5F); m_cstk[8'h10] = 14'h2A5F;
      #1 check("cs_wr_stall", 32'(mem_stall), 0);
      tick();
      cs_req(1'b0, 8'h10, 14'h0);
      #1 check("cs_rd_stall", 32'(mem_stall), 0);
      tick(); idle();
      check("cs_rd", 32'(call_stk_read_data), 32'h2A5F);
      exp_cs = 14'h2A5F;

      // Randomized main / call-stack traffic against array models.
      for (int i = 0; i < 16; i++) begin
         d = 12'($urandom); req(0, 1'b1, 17'(i), d); m_main[i] = d; tick();
         cs_req(1'b1, 8'(i), 14'($urandom)); m_cstk[i] = call_stk_write_data; tick();
      end
      idle();
      for (int n = 0; n < 60; n++) begin
         a = 4'($urandom_range(0, 15));
         hi = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0: begin d = 12'($urandom); req(0, 1'b1, {hi, 8'h00, a}, d); m_main[a] = d; end
            1: begin req(0, 1'b0, {hi, 8'h00, a}, 12'h0); exp_rd = m_main[a]; end
            2: begin cs_req(1'b1, {4'h0, a}, 14'($urandom)); m_cstk[a] = call_stk_write_data; end
            default: begin cs_req(1'b0, {4'h0, a}, 14'h0); exp_cs = m_cstk[a]; end
         endcase
         tick(); idle();
         check("rand_read_data", 32'(read_data), 32'(exp_rd));
         check("rand_cs_data", 32'(call_stk_read_data), 32'(exp_cs));
      end

      // Program memory write strobe, then unsupported read returns zero.
      req(2, 1'b1, 17'h12345, 12'h0F0);
      #1 check("prog_not_yet", 32'(prog_wr_en), 0);
      tick(); idle();
      check("prog_pulse", {prog_wr_en, prog_wr_addr, prog_wr_data}, {1'b1, 14'h2345, 12'h0F0});
      tick();
      check("prog_pulse_end", 32'(prog_wr_en), 0);
      req(0, 1'b0, 17'h00005, 12'h0); tick();
      req(2, 1'b0, 17'h00005, 12'h0); tick(); idle();
      check("prog_rd_zero", 32'(read_data), 0);

      // Direct frame-buffer write and read while the port is free.
      req(1, 1'b1, 17'h00100, 12'h111);
      #1 check("fb_direct_wr_port", {mem_stall, fb_port_en, fb_port_wen, fb_port_addr, fb_port_wdata},
               {1'b0, 1'b1, 1'b1, 17'h00100, 12'h111});
      tick();
      req(1, 1'b0, 17'h00100, 12'h0);
      #1 check("fb_direct_rd_port", {mem_stall, fb_port_en, fb_port_wen, fb_port_addr}, {1'b0, 1'b1, 1'b0, 17'h00100});
      tick(); idle(); tick();
      check("fb_direct_rd_data", 32'(read_data), 32'h111);

`ifdef FB_WBUF_EN
      // Fill the posted-write buffer while video owns the port.
      wr_log.delete(); wr_cyc.delete();
      fb_vid_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req(1, 1'b1, 17'h00100 + 17'(i), 12'h200 + 12'(i));
         #1 check($sformatf("fill_stall_%0d", i), {mem_stall, fb_port_en}, {(i == 4), 1'b0});
         if (i < 4) tick();
      end
      fb_vid_req = 1'b0;
      #1 check("fill_release", {mem_stall, fb_port_en, fb_port_addr}, {1'b0, 1'b1, 17'h00100});
      tick(); idle();
      for (int i = 0; i < 6; i++) tick();
      check("drain_count", wr_log.size(), 5);
      for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
         check($sformatf("drain_entry_%0d", i), 32'(wr_log[i]), 32'({17'h00100 + 17'(i), 12'h200 + 12'(i)}));
         if (i > 0) check($sformatf("drain_cycle_%0d", i), wr_cyc[i] - wr_cyc[i-1], 1);
      end

      // Read behind two posted writes waits for the buffer to empty.
      fb_vid_req = 1'b1;
      req(1, 1'b1, 17'h00100, 12'h3A1); tick();
      req(1, 1'b1, 17'h00101, 12'h3A2); tick();
      req(1, 1'b0, 17'h00100, 12'h0);
      #1 check("raw_stall_vid", 32'(mem_stall), 1);
      tick();
      check("raw_stall_vid2", {mem_stall, fb_port_en}, {1'b1, 1'b0});
      fb_vid_req = 1'b0;
      #1 k = 0;
      while (mem_stall && k < 10) begin tick(); k++; end
      check("raw_stall_cycles", k, 2);
      check("raw_rd_port", {fb_port_en, fb_port_wen, fb_port_addr}, {1'b1, 1'b0, 17'h00100});
      tick(); idle(); tick();
      check("raw_rd_data", 32'(read_data), 32'h3A1);
`else
      // Without the buffer any access waits for the port.
      fb_vid_req = 1'b1;
      req(1, 1'b1, 17'h00120, 12'h456);
      #1 check("nobuf_wr_stall", {mem_stall, fb_port_en}, {1'b1, 1'b0});
      tick();
      check("nobuf_wr_stall2", {mem_stall, fb_port_en}, {1'b1, 1'b0});
      fb_vid_req = 1'b0;
      #1 check("nobuf_wr_issue", {mem_stall, fb_port_en, fb_port_wen, fb_port_addr, fb_port_wdata},
               {1'b0, 1'b1, 1'b1, 17'h00120, 12'h456});
      tick();
      fb_vid_req = 1'b1;
      req(1, 1'b0, 17'h00120, 12'h0);
      #1 check("nobuf_rd_stall", {mem_stall, fb_port_en}, {1'b1, 1'b0});
      tick();
      fb_vid_req = 1'b0;
      #1 check("nobuf_rd_issue", {mem_stall, fb_port_en, fb_port_wen}, {1'b0, 1'b1, 1'b0});
      tick(); idle(); tick();
      check("nobuf_rd_data", 32'(read_data), 32'h456);
`endif

      // Illegal double request: nothing happens, sticky error.
      req(0, 1'b1, 17'h00005, 12'h777); fb_en = 1'b1;
      #1 check("illegal_no_stall_port", {mem_stall, fb_port_en}, 0);
      tick(); idle();
      check("illegal_err", 32'(mem_err), 1);
      req(0, 1'b0, 17'h00005, 12'h0); tick(); idle();
      check("illegal_no_write", 32'(read_data), 32'(m_main[5]));
      check("illegal_err_sticky", 32'(mem_err), 1);
      nreset = 1'b0;
      #2 check_reset_outputs("reset2");
      nreset = 1'b1;
      tick();
      check("post_reset_err", 32'(mem_err), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
